sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Shares the single SDRAM memory controller between three requesters: CPU (read/write), PPU (read-only) and an internal periodic auto-refresh generator.
- Sits between the NES core and the memory controller, and drives its single-cycle read_a/read_b/write/refresh command pulses.
- Converts them into per-requester req/ack handshakes with registered read data.
- Guarantees one outstanding operation at a time and a bounded refresh backlog.

Parameters:
- REFRESH_INTERVAL, 780: clk cycles between refresh ticks.
- REFRESH_URGENT, 2: pending-refresh level at which refresh pre-empts all requesters.
- OP_CYCLES, 4: cycles from command issue to data-valid and op completion; legal range 2..7.

Ports:
- clk  in  1  main logic clock
- resetn  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU request level; held with payload until cpu_ack
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  22  CPU byte address
- cpu_din  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_dout  out  8  CPU read data; valid from cpu_ack, held until next CPU read completes
- ppu_req  in  1  PPU read request level; held until ppu_ack
- ppu_addr  in  22  PPU byte address
- ppu_ack  out  1  one-cycle completion pulse
- ppu_dout  out  8  PPU read data; held as for cpu_dout
- mc_read_a  out  1  controller read, port a (CPU)
- mc_read_b  out  1  controller read, port b (PPU)
- mc_write  out  1  controller write
- mc_refresh  out  1  controller auto-refresh
- mc_addr  out  22  controller address
- mc_din  out  8  controller write data
- mc_busy  in  1  controller busy, including post-reset initialisation
- mc_dout_a  in  8  controller read data a
- mc_dout_b  in  8  controller read data b
- refresh_overflow  out  1  sticky: refresh backlog saturated

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - Refresh timer 0; pending count 0.
  - Reset asserted mid-operation aborts immediately: no ack is produced, and the in-flight latch and pending count are cleared.
- Refresh timer:
  - Free-running 0..REFRESH_INTERVAL-1; a tick occurs at the wrap.
  - A tick increments pending (3-bit, saturating at 7). A tick while pending==7 sets refresh_overflow, cleared only by reset.
  - Tick and refresh issue in the same cycle: pending unchanged.
  - The timer runs during controller init.
- FSM states: IDLE, WAIT.
- IDLE:
  - When mc_busy==0, select one source by fixed priority: pending>=REFRESH_URGENT (refresh) > ppu_req > cpu_req > pending>0 (refresh).
  - In the same cycle, drive exactly one mc_* command high for one cycle, with mc_addr/mc_din taken combinationally from the winner (mc_din=cpu_din for a CPU write, else 0).
  - Latch the winner ID and the payload, clear the op counter, and go to WAIT.
  - No request, or mc_busy==1 (e.g. init): all command outputs 0, remain in IDLE.
- WAIT:
  - Op counter increments each cycle.
  - At counter==OP_CYCLES-1 (i.e. OP_CYCLES cycles after the issue cycle T, at cycle T+OP_CYCLES):
    - CPU read: cpu_dout<=mc_dout_a.
    - PPU read: ppu_dout<=mc_dout_b.
    - Pulse the winner's ack in the following cycle: registered, visible at T+OP_CYCLES+1. CPU writes and refreshes produce no data update.
    - Go to IDLE.
  - mc_* commands are 0 throughout WAIT.
- Issue rate: the earliest next issue is the cycle the FSM re-enters IDLE, subject to mc_busy==0. A requester still holding req after its ack is treated as a new request.
- Fairness: PPU wins over CPU whenever both are pending; CPU is served whenever PPU is idle. Refresh below the urgent level waits for both.
- Requester protocol: req and payload stay stable from assertion until ack. Deasserting req before ack is illegal; the outcome is unspecified, but the FSM must still return to IDLE.

Test Plan:
- Init gating: release reset with mc_busy=1 for 50 cycles and cpu_req=1 read at 0x000123 -> no mc_* command during init; mc_read_a at the first cycle with mc_busy=0 and mc_addr=0x000123; cpu_ack OP_CYCLES+1 cycles later with cpu_dout equal to the modelled byte.
- CPU write then read: write 0xA5 to 0x3C0010, then read 0x3C0010 -> mc_write pulse with mc_din=0xA5, cpu_ack; then mc_read_a and cpu_dout=0xA5.
- Contention: cpu_req and ppu_req rise in the same cycle -> PPU issued first (mc_read_b), CPU issued on the next IDLE cycle; each ack pulses exactly once.
- Refresh urgency: hold ppu_req continuously with REFRESH_INTERVAL=16 -> after 2 ticks mc_refresh pre-empts the PPU; pending never exceeds 2; refresh_overflow stays 0.
- Overflow: hold mc_busy=1 for 8*REFRESH_INTERVAL cycles -> pending saturates at 7, refresh_overflow=1 and stays 1 after mc_busy falls, until reset.
- Reset mid-op: assert resetn=0 two cycles after a CPU read issue -> cpu_ack never pulses, all outputs 0 immediately; normal operation resumes after release.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Shares one SDRAM memory controller between the CPU (read/write), the PPU
// (read-only) and an internal periodic auto-refresh generator. Only one
// operation is outstanding at a time. Each operation ends with a registered
// one-cycle ack to its requester. Read data is registered and held.
//
// Ports
//   clk, resetn                  clock, asynchronous active-low reset
//   cpu_req/we/addr/din          CPU request level and payload
//   cpu_ack, cpu_dout            CPU completion pulse, held read data
//   ppu_req/addr                 PPU read request level and address
//   ppu_ack, ppu_dout            PPU completion pulse, held read data
//   mc_read_a/read_b/write/refresh  single-cycle controller commands
//   mc_addr, mc_din              controller address and write data
//   mc_busy                      controller busy (including its init)
//   mc_dout_a, mc_dout_b         controller read data, ports a and b
//   refresh_overflow             sticky flag: refresh backlog saturated
//
// state | meaning
// IDLE  | choose a source and issue its command when the controller is free
// WAIT  | operation in flight; count OP_CYCLES, then capture data and ack

module sdram_arbiter #(
    parameter int REFRESH_INTERVAL = 780,
    parameter int REFRESH_URGENT   = 2,
    parameter int OP_CYCLES        = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [21:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic [7:0]  cpu_dout,
    input  logic        ppu_req,
    input  logic [21:0] ppu_addr,
    output logic        ppu_ack,
    output logic [7:0]  ppu_dout,
    output logic        mc_read_a,
    output logic        mc_read_b,
    output logic        mc_write,
    output logic        mc_refresh,
    output logic [21:0] mc_addr,
    output logic [7:0]  mc_din,
    input  logic        mc_busy,
    input  logic [7:0]  mc_dout_a,
    input  logic [7:0]  mc_dout_b,
    output logic        refresh_overflow
);

    localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [TW-1:0] TMAX    = TW'(REFRESH_INTERVAL - 1);
    localparam logic [2:0]    URG     = 3'(REFRESH_URGENT);
    localparam logic [2:0]    OP_LAST = 3'(OP_CYCLES - 1);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic [1:0] {SRC_REF, SRC_PPU, SRC_CPU} src_t;

    state_t        state, state_nxt;
    src_t          src_sel, src_q;
    logic          issue;
    logic          we_q;
    logic [21:0]   addr_q;
    logic [7:0]    din_q;
    logic [2:0]    op_cnt;
    logic [2:0]    pending;
    logic [TW-1:0] timer;
    logic          tick;
    logic          op_done;
    logic          refresh_issue;

    assign tick          = (timer == TMAX);
    assign op_done       = (state == WAIT) && (op_cnt == OP_LAST);
    assign refresh_issue = issue && (src_sel == SRC_REF);

    // Issue is qualified by resetn so that asserting reset forces every
    // output low at once, even while a requester still holds its request.
    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        src_sel    = SRC_REF;
        mc_read_a  = 1'b0;
        mc_read_b  = 1'b0;
        mc_write   = 1'b0;
        mc_refresh = 1'b0;
        mc_addr    = addr_q;
        mc_din     = din_q;
        case (state)
            IDLE: begin
                if (resetn && !mc_busy) begin
                    if (pending >= URG) begin
                        issue = 1'b1; src_sel = SRC_REF;
                    end else if (ppu_req) begin
                        issue = 1'b1; src_sel = SRC_PPU;
                    end else if (cpu_req) begin
                        issue = 1'b1; src_sel = SRC_CPU;
                    end else if (pending != 3'd0) begin
                        issue = 1'b1; src_sel = SRC_REF;
                    end
                end
                if (issue) begin
                    state_nxt = WAIT;
                    case (src_sel)
                        SRC_PPU: begin
                            mc_read_b = 1'b1;
                            mc_addr   = ppu_addr;
                            mc_din    = 8'd0;
                        end
                        SRC_CPU: begin
                            mc_write  = cpu_we;
                            mc_read_a = !cpu_we;
                            mc_addr   = cpu_addr;
                            mc_din    = cpu_we ? cpu_din : 8'd0;
                        end
                        default: begin
                            mc_refresh = 1'b1;
                            mc_addr    = 22'd0;
                            mc_din     = 8'd0;
                        end
                    endcase
                end
            end
            WAIT: begin
                if (op_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            src_q            <= SRC_REF;
            we_q             <= 1'b0;
            addr_q           <= 22'd0;
            din_q            <= 8'd0;
            op_cnt           <= 3'd0;
            timer            <= '0;
            pending          <= 3'd0;
            refresh_overflow <= 1'b0;
            cpu_ack          <= 1'b0;
            ppu_ack          <= 1'b0;
            cpu_dout         <= 8'd0;
            ppu_dout         <= 8'd0;
        end else begin
            state <= state_nxt;
            timer <= tick ? '0 : timer + 1'b1;

            // A tick and a refresh issue in the same cycle cancel out.
            if (tick && !refresh_issue) begin
                if (pending != 3'd7) pending <= pending + 3'd1;
            end else if (!tick && refresh_issue) begin
                pending <= pending - 3'd1;
            end
            if (tick && pending == 3'd7) refresh_overflow <= 1'b1;

            if (issue) begin
                op_cnt <= 3'd0;
                src_q  <= src_sel;
                we_q   <= (src_sel == SRC_CPU) && cpu_we;
                addr_q <= mc_addr;
                din_q  <= mc_din;
            end else if (state == WAIT) begin
                op_cnt <= op_cnt + 3'd1;
            end

            cpu_ack <= op_done && (src_q == SRC_CPU);
            ppu_ack <= op_done && (src_q == SRC_PPU);
            if (op_done && src_q == SRC_CPU && !we_q) cpu_dout <= mc_dout_a;
            if (op_done && src_q == SRC_PPU)          ppu_dout <= mc_dout_b;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
// Directed bench for sdram_arbiter. Instance dut uses the default refresh
// interval and a behavioural controller model for the functional tests.
// Instance dut_r uses a 16-cycle interval for the refresh urgency and
// overflow tests.

module tb_sdram_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance 1 signals ----------------
    logic        resetn, cpu_req, cpu_we, ppu_req, mc_busy;
    logic [21:0] cpu_addr, ppu_addr;
    logic [7:0]  cpu_din, mc_dout_a, mc_dout_b;
    logic        cpu_ack, ppu_ack, mc_read_a, mc_read_b, mc_write, mc_refresh;
    logic        refresh_overflow;
    logic [7:0]  cpu_dout, ppu_dout, mc_din;
    logic [21:0] mc_addr;
    logic [63:0] outs;

    assign outs = {11'd0, cpu_ack, cpu_dout, ppu_ack, ppu_dout, mc_read_a, mc_read_b,
                   mc_write, mc_refresh, mc_addr, mc_din, refresh_overflow};

    sdram_arbiter #(.REFRESH_INTERVAL(780), .REFRESH_URGENT(2), .OP_CYCLES(4)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_dout(ppu_dout),
        .mc_read_a(mc_read_a), .mc_read_b(mc_read_b), .mc_write(mc_write),
        .mc_refresh(mc_refresh), .mc_addr(mc_addr), .mc_din(mc_din),
        .mc_busy(mc_busy), .mc_dout_a(mc_dout_a), .mc_dout_b(mc_dout_b),
        .refresh_overflow(refresh_overflow)
    );

    // ---------------- instance 2 signals ----------------
    logic        r_resetn, r_cpu_req, r_cpu_we, r_ppu_req, r_mc_busy;
    logic [21:0] r_cpu_addr, r_ppu_addr;
    logic [7:0]  r_cpu_din, r_mc_dout_a, r_mc_dout_b;
    logic        r_cpu_ack, r_ppu_ack, r_mc_read_a, r_mc_read_b, r_mc_write, r_mc_refresh;
    logic        r_refresh_overflow;
    logic [7:0]  r_cpu_dout, r_ppu_dout, r_mc_din;
    logic [21:0] r_mc_addr;

    sdram_arbiter #(.REFRESH_INTERVAL(16), .REFRESH_URGENT(2), .OP_CYCLES(4)) dut_r (
        .clk(clk), .resetn(r_resetn),
        .cpu_req(r_cpu_req), .cpu_we(r_cpu_we), .cpu_addr(r_cpu_addr), .cpu_din(r_cpu_din),
        .cpu_ack(r_cpu_ack), .cpu_dout(r_cpu_dout),
        .ppu_req(r_ppu_req), .ppu_addr(r_ppu_addr), .ppu_ack(r_ppu_ack), .ppu_dout(r_ppu_dout),
        .mc_read_a(r_mc_read_a), .mc_read_b(r_mc_read_b), .mc_write(r_mc_write),
        .mc_refresh(r_mc_refresh), .mc_addr(r_mc_addr), .mc_din(r_mc_din),
        .mc_busy(r_mc_busy), .mc_dout_a(r_mc_dout_a), .mc_dout_b(r_mc_dout_b),
        .refresh_overflow(r_refresh_overflow)
    );

    // ---------------- controller model for instance 1 ----------------
    logic [7:0] mem [logic [21:0]];

    function automatic logic [7:0] pat(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
    endfunction

    function automatic logic [7:0] rd(input logic [21:0] a);
        if (mem.exists(a)) return mem[a];
        return pat(a);
    endfunction

    always @(posedge clk) begin
        if (mc_write)  mem[mc_addr] = mc_din;
        if (mc_read_a) mc_dout_a <= rd(mc_addr);
        if (mc_read_b) mc_dout_b <= rd(mc_addr);
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cmd_bit(input int w);
        case (w)
            0:       return mc_read_a;
            1:       return mc_read_b;
            2:       return mc_write;
            default: return mc_refresh;
        endcase
    endfunction

    // Waits (bounded) until the selected command is high in the current cycle.
    task automatic wait_cmd(input int w, output logic seen);
        int n = 0;
        while (!cmd_bit(w) && n < 30) begin
            tick();
            n++;
        end
        seen = cmd_bit(w);
    endtask

    // Cycles from the issue cycle to the cpu_ack cycle (bounded at 20).
    task automatic cpu_latency(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!cpu_ack && n < 20);
    endtask

    initial begin
        int   n, cmds, ppu_acks, cpu_acks, cpu_issue, first_ref, ref_cnt, pmax;
        logic seen, ovf;

        resetn = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h000123;
        cpu_din = 8'h00; ppu_req = 1'b0; ppu_addr = 22'h0; mc_busy = 1'b1;
        r_resetn = 1'b0; r_cpu_req = 1'b0; r_cpu_we = 1'b0; r_cpu_addr = 22'h0;
        r_cpu_din = 8'h0; r_ppu_req = 1'b0; r_ppu_addr = 22'h000015; r_mc_busy = 1'b0;
        r_mc_dout_a = 8'h0; r_mc_dout_b = 8'h0;
        repeat (3) tick();
        chk("reset_outs", outs, 64'd0);

        // Init gating: controller busy for 50 cycles after reset release.
        resetn = 1'b1;
        #1;
        cmds = 0;
        repeat (50) begin
            if (mc_read_a | mc_read_b | mc_write | mc_refresh) cmds++;
            tick();
        end
        chk("init_quiet", 64'(cmds), 64'd0);
        mc_busy = 1'b0;
        #1;
        chk("init_read_a", 64'(mc_read_a), 64'd1);
        chk("init_addr", 64'(mc_addr), 64'h000123);
        cpu_latency(n);
        chk("init_latency", 64'(n), 64'd5);
        chk("init_dout", 64'(cpu_dout), 64'h78);
        cpu_req = 1'b0;
        #1;

        // CPU write 0xA5 to 0x3C0010, then read it back.
        cpu_we = 1'b1; cpu_addr = 22'h3C0010; cpu_din = 8'hA5; cpu_req = 1'b1;
        #1;
        wait_cmd(2, seen);
        chk("wr_seen", 64'(seen), 64'd1);
        chk("wr_din", 64'(mc_din), 64'hA5);
        chk("wr_addr", 64'(mc_addr), 64'h3C0010);
        cpu_latency(n);
        chk("wr_latency", 64'(n), 64'd5);
        chk("wr_dout_hold", 64'(cpu_dout), 64'h78);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_din = 8'h00;
        #1;
        cpu_req = 1'b1;
        #1;
        wait_cmd(0, seen);
        chk("rd_seen", 64'(seen), 64'd1);
        chk("rd_addr", 64'(mc_addr), 64'h3C0010);
        cpu_latency(n);
        chk("rd_latency", 64'(n), 64'd5);
        chk("rd_dout", 64'(cpu_dout), 64'hA5);
        cpu_req = 1'b0;
        tick();

        // Contention: CPU and PPU requests rise together.
        cpu_addr = 22'h001000; ppu_addr = 22'h002000;
        cpu_req = 1'b1; ppu_req = 1'b1;
        #1;
        chk("cont_read_b", 64'(mc_read_b), 64'd1);
        chk("cont_no_read_a", 64'(mc_read_a), 64'd0);
        chk("cont_addr", 64'(mc_addr), 64'h002000);
        ppu_acks = 0; cpu_acks = 0; cpu_issue = -1; cmds = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (ppu_ack) begin ppu_acks++; ppu_req = 1'b0; end
            if (cpu_ack) begin cpu_acks++; cpu_req = 1'b0; end
            #1;
            if (mc_read_a && cpu_issue < 0) cpu_issue = i;
            if (mc_read_a | mc_read_b | mc_write | mc_refresh) cmds++;
        end
        chk("cont_cpu_issue", 64'(cpu_issue), 64'd5);
        chk("cont_ppu_acks", 64'(ppu_acks), 64'd1);
        chk("cont_cpu_acks", 64'(cpu_acks), 64'd1);
        chk("cont_cmds", 64'(cmds), 64'd1);
        chk("cont_ppu_dout", 64'(ppu_dout), 64'h7A);
        chk("cont_cpu_dout", 64'(cpu_dout), 64'h4A);

        // Reset two cycles after a CPU read issue.
        cpu_addr = 22'h000777; cpu_req = 1'b1;
        #1;
        wait_cmd(0, seen);
        chk("rst_issue", 64'(seen), 64'd1);
        tick(); tick();
        resetn = 1'b0;
        #1;
        chk("rst_outs", outs, 64'd0);
        n = 0;
        repeat (6) begin
            tick();
            if (cpu_ack) n++;
        end
        resetn = 1'b1;
        #1;
        chk("rst_no_ack", 64'(n), 64'd0);
        chk("rst_resume", 64'(mc_read_a), 64'd1);
        cpu_latency(n);
        chk("rst_latency", 64'(n), 64'd5);
        chk("rst_dout", 64'(cpu_dout), 64'h2A);
        cpu_req = 1'b0;

        // Refresh urgency on dut_r: PPU requests continuously.
        r_ppu_req = 1'b1;
        tick();
        r_resetn = 1'b1;
        #1;
        first_ref = -1; ref_cnt = 0; pmax = 0; ovf = 1'b0;
        for (int c = 0; c < 152; c++) begin
            if (r_mc_refresh) begin
                if (first_ref < 0) first_ref = c;
                ref_cnt++;
            end
            if (int'(dut_r.pending) > pmax) pmax = int'(dut_r.pending);
            if (r_refresh_overflow) ovf = 1'b1;
            tick();
        end
        chk("urg_first", 64'(first_ref), 64'd35);
        chk("urg_count", 64'(ref_cnt), 64'd8);
        chk("urg_pending_max", 64'(pmax), 64'd2);
        chk("urg_overflow", 64'(ovf), 64'd0);

        // Overflow on dut_r: controller busy for more than 8 intervals.
        r_resetn = 1'b0; r_ppu_req = 1'b0; r_mc_busy = 1'b1;
        tick();
        r_resetn = 1'b1;
        #1;
        cmds = 0;
        for (int c = 0; c < 130; c++) begin
            if (c == 120) chk("ovf_before", 64'(r_refresh_overflow), 64'd0);
            if (r_mc_read_a | r_mc_read_b | r_mc_write | r_mc_refresh) cmds++;
            tick();
        end
        chk("ovf_set", 64'(r_refresh_overflow), 64'd1);
        chk("ovf_pending", 64'(dut_r.pending), 64'd7);
        chk("ovf_quiet", 64'(cmds), 64'd0);
        r_mc_busy = 1'b0;
        #1;
        ref_cnt = 0;
        repeat (40) begin
            if (r_mc_refresh) ref_cnt++;
            tick();
        end
        chk("ovf_drained", 64'(ref_cnt >= 7), 64'd1);
        chk("ovf_sticky", 64'(r_refresh_overflow), 64'd1);
        r_resetn = 1'b0;
        #1;
        chk("ovf_reset", 64'(r_refresh_overflow), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
